// File: rtl/ip_bus_initiator_pkg.sv
// ip_bus_initiator_pkg: shared system bus widths and initiator state encoding
package ip_bus_initiator_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } state_t;
endpackage

// File: rtl/ip_bus_initiator.sv
// ip_bus_initiator: single-outstanding bus master with read timeout and one-cycle response pulse
module ip_bus_initiator
   import ip_bus_initiator_pkg::*;
#(
   parameter int                TIMEOUT_CYCLES = 255,
   parameter int                TIMEOUT_W      = 8,
   parameter logic [DATA_W-1:0] TIMEOUT_DATA   = 8'hFF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_address,
   input  logic              cmd_memreq,
   input  logic              cmd_write,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] bus_address,
   output logic              bus_memreq,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic              bus_write,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_rdata_en
);
   state_t               state, state_nxt;
   logic [TIMEOUT_W-1:0] cnt;
   logic [DATA_W-1:0]    rdata_q;
   logic                 to_q;
   logic                 expired;

   // WAIT lasts exactly TIMEOUT_CYCLES cycles; a strobe in the last one still wins
   assign expired = cnt >= TIMEOUT_W'(TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk)
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (cmd_valid) state_nxt = ST_REQ;
         ST_REQ:  if (bus_ready) state_nxt = bus_write ? ST_RESP : ST_WAIT;
         ST_WAIT: if (bus_rdata_en || expired) state_nxt = ST_RESP;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready   = state == ST_IDLE;
      bus_valid   = state == ST_REQ;
      rsp_valid   = state == ST_RESP;
      rsp_rdata   = state == ST_RESP ? rdata_q : '0;
      rsp_timeout = state == ST_RESP && to_q;
   end

   always_ff @(posedge clk)
      if (!reset_n) begin
         bus_address <= '0;
         bus_memreq  <= 1'b0;
         bus_write   <= 1'b0;
         bus_wdata   <= '0;
         cnt         <= '0;
         rdata_q     <= '0;
         to_q        <= 1'b0;
      end else begin
         if (state == ST_IDLE && cmd_valid) begin
            bus_address <= cmd_address;
            bus_memreq  <= cmd_memreq;
            bus_write   <= cmd_write;
            bus_wdata   <= cmd_wdata;
            rdata_q     <= '0;
            to_q        <= 1'b0;
         end
         if (state == ST_REQ)                       cnt <= '0;
         else if (state == ST_WAIT && cnt != '1)    cnt <= cnt + 1'b1;
         if (state == ST_WAIT && bus_rdata_en)      rdata_q <= bus_rdata;
         else if (state == ST_WAIT && expired) begin
            rdata_q <= TIMEOUT_DATA;
            to_q    <= 1'b1;
         end
      end
endmodule

// File: tb/tb_ip_bus_initiator.sv
// tb_ip_bus_initiator: randomized and directed checks against a latency/outcome model
module tb_ip_bus_initiator;
   localparam int         TC = 255;
   localparam logic [7:0] TD = 8'hFF;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cmd_valid, cmd_ready, cmd_memreq, cmd_write;
   logic [15:0] cmd_address, bus_address;
   logic [7:0]  cmd_wdata, rsp_rdata, bus_wdata, bus_rdata;
   logic        rsp_valid, rsp_timeout, bus_memreq, bus_valid, bus_ready, bus_write, bus_rdata_en;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   ip_bus_initiator #(.TIMEOUT_CYCLES(TC), .TIMEOUT_W(8), .TIMEOUT_DATA(TD)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_address(cmd_address),
      .cmd_memreq(cmd_memreq), .cmd_write(cmd_write), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
      .bus_address(bus_address), .bus_memreq(bus_memreq), .bus_valid(bus_valid),
      .bus_ready(bus_ready), .bus_write(bus_write), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One command issued in cycle T; responder answers after d wait cycles, strobe e cycles after accept.
   // Outcome is derived from the response rules: latency, data and timeout flag per command.
   task automatic txn(input logic [15:0] a, input logic m, input logic w, input logic [7:0] wd,
                      input int d, input int e, input logic [7:0] rd, input bit stray, input int abort_c);
      int         rsp_c, last;
      logic [7:0] exp_d;
      logic       exp_to, alive, strobe;
      if (w)            begin rsp_c = 2 + d;      exp_d = 8'h00; exp_to = 1'b0; end
      else if (e <= TC) begin rsp_c = 2 + d + e;  exp_d = rd;    exp_to = 1'b0; end
      else              begin rsp_c = 2 + d + TC; exp_d = TD;    exp_to = 1'b1; end
      last = abort_c > 0 ? abort_c + 3 : rsp_c + 1;
      chk("cmd_ready_at_issue", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_address = a; cmd_memreq = m; cmd_write = w; cmd_wdata = wd;
      bus_ready = 1'($urandom);
      bus_rdata_en = stray;
      bus_rdata = stray ? 8'($urandom) : 8'h00;
      @(negedge clk);
      cmd_valid = 1'b0; cmd_address = 16'($urandom); cmd_wdata = 8'($urandom);
      for (int c = 1; c <= last; c++) begin
         alive = abort_c == 0 || c <= abort_c;
         chk("bus_valid", bus_valid, alive && c <= 1 + d);
         chk("rsp_valid", rsp_valid, alive && c == rsp_c);
         chk("rsp_rdata", rsp_rdata, (alive && c == rsp_c) ? exp_d : 8'h00);
         chk("rsp_timeout", rsp_timeout, alive && c == rsp_c && exp_to);
         chk("cmd_ready", cmd_ready, !alive || c > rsp_c);
         chk("bus_fields", {bus_address, bus_memreq, bus_write, bus_wdata}, alive ? {a, m, w, wd} : 26'h0);
         reset_n = !(c == abort_c);
         bus_ready = c < 1 + d ? 1'b0 : c == 1 + d ? 1'b1 : 1'($urandom);
         strobe = !w && alive && e <= TC && c == 1 + d + e;
         bus_rdata_en = strobe || (stray && (c <= 1 + d || c >= rsp_c) && 1'($urandom));
         bus_rdata = strobe ? rd : bus_rdata_en ? 8'($urandom) : 8'h00;
         @(negedge clk);
      end
      reset_n = 1'b1; bus_ready = 1'b0; bus_rdata_en = 1'b0; bus_rdata = 8'h00;
   endtask

   initial begin
      reset_n = 1'b0; cmd_valid = 1'b0; cmd_address = '0; cmd_memreq = 1'b0; cmd_write = 1'b0;
      cmd_wdata = '0; bus_ready = 1'b0; bus_rdata = '0; bus_rdata_en = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_bus_valid", bus_valid, 0);
      chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, 0);
      chk("rst_bus_fields", {bus_address, bus_memreq, bus_write, bus_wdata}, 0);
      reset_n = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      txn(16'h0000, 1'b1, 1'b0, 8'h00, 0, 1, 8'hF3, 1'b0, 0);
      txn(16'h0010, 1'b0, 1'b1, 8'h41, 0, 1, 8'h00, 1'b0, 0);
      txn(16'hBEEF, 1'b1, 1'b0, 8'h00, 5, 1, 8'h77, 1'b0, 0);
      txn(16'h1234, 1'b0, 1'b1, 8'h9C, 5, 1, 8'h00, 1'b0, 0);
      txn(16'h0030, 1'b0, 1'b0, 8'h00, 0, TC + 100, 8'h00, 1'b0, 0);
      txn(16'h4000, 1'b1, 1'b0, 8'h00, 2, 3, 8'h5A, 1'b1, 0);
      txn(16'h0031, 1'b0, 1'b0, 8'h00, 0, TC, 8'hC3, 1'b0, 0);
      txn(16'h0032, 1'b0, 1'b0, 8'h00, 1, TC + 1, 8'hC4, 1'b0, 0);
      txn(16'h5555, 1'b1, 1'b0, 8'h00, 1, TC + 100, 8'h00, 1'b0, 10);
      txn(16'h6666, 1'b1, 1'b1, 8'h00, 3, 1, 8'h00, 1'b0, 2);
      txn(16'h0001, 1'b1, 1'b0, 8'h00, 0, 1, 8'hA5, 1'b0, 0);
      for (int i = 0; i < 60; i++)
         txn(16'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), $urandom_range(0, 3),
             $urandom_range(1, 6), 8'($urandom), 1'($urandom), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
